hw1_result_collector: RTL and testbench
=======================================

// Module: hw1_result_collector
// PURPOSE
//  Downstream of the hw1 mux stage: samples its 1-bit O1 result stream and packs WIDTH
//  consecutive bits, LSB first, into one word. The word goes out with a count of ones and
//  the sel mode of the frame, over a valid/ready handshake.
//  Gives the bench and next stage word-level results instead of per-cycle bits.
// PARAMETERS
//  WIDTH  8                    bits per frame (>=2)
//  CNT_W  $clog2(WIDTH+1)      width of ones count (derived; not overridden)
// PORTS
//  clk          in   1      single clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  bit_valid    in   1      bit_in/bit_sel valid this cycle
//  bit_in       in   1      O1 result bit from hw1
//  bit_sel      in   1      sel value that produced bit_in
//  frame_start  in   1      qualifies bit_valid: this bit is index 0 of a new frame
//  out_valid    out  1      packed word available
//  out_ready    in   1      consumer accepts word
//  out_data     out  WIDTH  packed bits, bit i = i-th bit of frame
//  out_ones     out  CNT_W  number of 1s in out_data
//  out_mode     out  1      bit_sel latched at frame start
//  drop_err     out  1      one-cycle pulse: a bit or a partial frame was discarded
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE; out_valid=0, out_data=0, out_ones=0, out_mode=0,
//   drop_err=0, index counter=0. A reset mid-frame discards the partial frame with no drop_err.
//  States: IDLE, COLLECT, HOLD. Registered outputs only; drop_err registered, high 1 cycle.
//  IDLE: bit_valid&frame_start -> out_data cleared then bit0=bit_in, ones=bit_in,
//   mode=bit_sel, idx=1, ->COLLECT. bit_valid without frame_start: ignored, no error.
//  COLLECT: bit_valid&!frame_start&(bit_sel==mode) -> out_data[idx]=bit_in, ones+=bit_in,
//   idx++; when idx reaches WIDTH-1 on this write -> HOLD.
//   bit_valid&frame_start -> partial frame discarded, drop_err, restart as in IDLE.
//   bit_valid&!frame_start&(bit_sel!=mode) -> frame discarded, drop_err, ->IDLE.
//   no bit_valid: hold all state; gaps between bits unlimited.
//  HOLD: out_valid=1; out_data/out_ones/out_mode stable until accepted.
//   out_ready -> word accepted at that edge; out_valid low next cycle unless restart below.
//   Same-cycle out_ready & bit_valid&frame_start -> accept AND start new frame (->COLLECT),
//   no bubble. bit_valid without out_ready, or without frame_start -> bit dropped, drop_err,
//   stay HOLD.
//  Latency: last bit sampled at edge k -> out_valid=1 after edge k; min frame period WIDTH cycles.
//  out_valid never drops without out_ready (AXI-style); out_ready while !out_valid ignored.
//  Arithmetic: ones saturates by construction (<=WIDTH fits CNT_W); idx wraps never (reset at start).
// STRUCTURE
//  Shared include hw1_pkg.vh: state encodings (ST_IDLE=2'd0, ST_COLLECT=2'd1, ST_HOLD=2'd2)
//   and default WIDTH; used by RTL and bench.
//  Single module; no sub-module. hw1 is instantiated only in the bench as the bit source.
// TESTING
//  1 Reset: assert rst_n=0 mid-COLLECT -> all outputs 0, state IDLE, no drop_err.
//  2 Frame from hw1 sel=0 (a^b^c), bits 1,0,1,1,0,0,1,0 -> out_data=8'h4D, out_ones=4,
//    out_mode=0, out_valid one cycle after 8th bit.
//  3 Backpressure: out_ready=0 for 5 cycles in HOLD -> data stable; extra bit_valid
//    -> drop_err pulse, word unchanged; out_ready=1 -> out_valid=0 next cycle.
//  4 Back-to-back: out_ready=1 with frame_start same cycle -> second frame sel=1 all 1s
//    -> 8'hFF, ones=8, mode=1, no idle cycle between frames.
//  5 Abort: frame_start at index 3 -> drop_err, new frame index 0; bit_sel flip at
//    index 5 -> drop_err, IDLE, no out_valid.
//  6 Random gaps: bit_valid 30% duty, 100 frames vs scoreboard of hw1 model -> exact match.

Source files
------------

// File: rtl/hw1_result_collector_pkg.sv
// Shared definitions for the hw1 result collector: FSM state encoding and the default frame width.
package hw1_result_collector_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/hw1_result_collector.sv
// Packs WIDTH consecutive hw1 O1 result bits (LSB first) into a word with ones count and sel mode,
// then presents the word on a valid/ready handshake.
module hw1_result_collector
    import hw1_result_collector_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             bit_sel,
    input  logic             frame_start,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] out_ones,
    output logic             out_mode,
    output logic             drop_err
);

    localparam int IDX_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic [CNT_W-1:0] ones_reg, ones_next;
    logic             mode_reg, mode_next;
    logic             valid_reg, valid_next;
    logic             drop_reg, drop_next;
    logic             restart;
    logic             start_hit;
    logic [CNT_W-1:0] bit_cnt;

    assign start_hit = bit_valid & frame_start;
    assign bit_cnt   = CNT_W'(bit_in);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            idx_reg   <= '0;
            data_reg  <= '0;
            ones_reg  <= '0;
            mode_reg  <= 1'b0;
            valid_reg <= 1'b0;
            drop_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            data_reg  <= data_next;
            ones_reg  <= ones_next;
            mode_reg  <= mode_next;
            valid_reg <= valid_next;
            drop_reg  <= drop_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        data_next  = data_reg;
        ones_next  = ones_reg;
        mode_next  = mode_reg;
        valid_next = valid_reg;
        drop_next  = 1'b0;
        restart    = 1'b0;

        unique case (state_reg)
            ST_IDLE: begin
                restart = start_hit;
            end
            ST_COLLECT: begin
                if (bit_valid) begin
                    if (frame_start) begin
                        restart   = 1'b1;
                        drop_next = 1'b1;
                    end else if (bit_sel != mode_reg) begin
                        drop_next  = 1'b1;
                        state_next = ST_IDLE;
                        idx_next   = '0;
                    end else begin
                        data_next[idx_reg] = bit_in;
                        ones_next          = ones_reg + bit_cnt;
                        if (idx_reg == LAST_IDX) begin
                            idx_next   = '0;
                            state_next = ST_HOLD;
                            valid_next = 1'b1;
                        end else begin
                            idx_next = idx_reg + IDX_W'(1);
                        end
                    end
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    if (start_hit) begin
                        restart = 1'b1;
                    end else begin
                        // word leaves; a stray non-start bit this cycle is still lost
                        state_next = ST_IDLE;
                        drop_next  = bit_valid;
                    end
                end else begin
                    drop_next = bit_valid;
                end
            end
            default: begin
                state_next = ST_IDLE;
                idx_next   = '0;
                valid_next = 1'b0;
            end
        endcase

        if (restart) begin
            data_next  = {{(WIDTH-1){1'b0}}, bit_in};
            ones_next  = bit_cnt;
            mode_next  = bit_sel;
            idx_next   = IDX_W'(1);
            valid_next = 1'b0;
            state_next = ST_COLLECT;
        end
    end

    assign out_valid = valid_reg;
    assign out_data  = data_reg;
    assign out_ones  = ones_reg;
    assign out_mode  = mode_reg;
    assign drop_err  = drop_reg;

endmodule

// File: tb/tb_hw1_result_collector.sv
// Scoreboard bench for hw1_result_collector; bits come from a behavioural hw1 O1 model.
module tb_hw1_result_collector;
    import hw1_result_collector_pkg::*;

    localparam int WIDTH = DEFAULT_WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [CNT_W-1:0] ones;
        logic             mode;
    } word_t;

    word_t exp_q[$];
    int tests_run = 0;
    int tests_failed = 0;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             bit_valid = 1'b0;
    logic             bit_in = 1'b0;
    logic             bit_sel = 1'b0;
    logic             frame_start = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_ones;
    logic             out_mode;
    logic             drop_err;

    always #5 clk = ~clk;

    hw1_result_collector #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .bit_valid(bit_valid), .bit_in(bit_in), .bit_sel(bit_sel),
        .frame_start(frame_start), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_ones(out_ones), .out_mode(out_mode), .drop_err(drop_err)
    );

    // hw1 O1 stage: sel=0 gives a^b^c, sel=1 gives (a&b)|c
    function automatic logic hw1_o1(input logic sel, input logic a, input logic b, input logic c);
        return sel ? ((a & b) | c) : (a ^ b ^ c);
    endfunction

    function automatic logic [CNT_W-1:0] popcnt(input logic [WIDTH-1:0] d);
        logic [CNT_W-1:0] n = '0;
        for (int i = 0; i < WIDTH; i++) n = n + CNT_W'(d[i]);
        return n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s, input logic fs);
        bit_valid = 1'b1; bit_in = b; bit_sel = s; frame_start = fs;
        tick();
        bit_valid = 1'b0; frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        send_bit(1'b1, 1'b1, 1'b1);
        send_bit(1'b1, 1'b1, 1'b0);
        send_bit(1'b1, 1'b1, 1'b0);
        tests_run++; if (out_data !== 8'h07 || out_mode !== 1'b1) begin tests_failed++; $display("FAIL reset_precollect data=%h mode=%b want 07/1", out_data, out_mode); end
        #2 rst_n = 1'b0;
        #1;
        tests_run++; if ({out_valid, out_data, out_ones, out_mode, drop_err} !== '0) begin tests_failed++; $display("FAIL reset_outputs v=%b d=%h o=%0d m=%b e=%b want all 0", out_valid, out_data, out_ones, out_mode, drop_err); end
        tests_run++; if (dut.state_reg !== ST_IDLE || dut.idx_reg !== '0) begin tests_failed++; $display("FAIL reset_state state=%0d idx=%0d want 0/0", dut.state_reg, dut.idx_reg); end
        tick();
        tests_run++; if (drop_err !== 1'b0) begin tests_failed++; $display("FAIL reset_no_drop drop_err=%b want 0", drop_err); end
        rst_n = 1'b1;
        tick();
        send_bit(1'b1, 1'b0, 1'b0);
        tests_run++; if (drop_err !== 1'b0 || out_data !== '0 || dut.state_reg !== ST_IDLE) begin tests_failed++; $display("FAIL idle_ignore drop=%b data=%h state=%0d want 0/00/0", drop_err, out_data, dut.state_reg); end
        $display("[TB] reset: done");
    endtask

    task automatic test_frame();
        logic [WIDTH-1:0] pat = 8'h4D;
        word_t w, got;
        logic r;
        w.data = pat; w.ones = popcnt(pat); w.mode = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            r = 1'($urandom_range(0, 1));
            if (i == WIDTH - 1) exp_q.push_back(w);
            send_bit(hw1_o1(1'b0, pat[i], r, r), 1'b0, i == 0);
            if (i < WIDTH - 1) begin
                tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL frame_early_valid bit=%0d out_valid=%b want 0", i, out_valid); end
            end
        end
        tests_run++; if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL frame_valid out_valid=%b want 1", out_valid); end
        got = exp_q.pop_front();
        tests_run++; if (out_data !== got.data || out_data !== 8'h4D) begin tests_failed++; $display("FAIL frame_data data=%h want %h", out_data, got.data); end
        tests_run++; if (out_ones !== got.ones || out_ones !== 4'd4) begin tests_failed++; $display("FAIL frame_ones ones=%0d want %0d", out_ones, got.ones); end
        tests_run++; if (out_mode !== got.mode) begin tests_failed++; $display("FAIL frame_mode mode=%b want %b", out_mode, got.mode); end
        $display("[TB] frame: word data=%h ones=%0d mode=%b", out_data, out_ones, out_mode);
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests_run++; if (out_valid !== 1'b1 || out_data !== 8'h4D || out_ones !== 4'd4) begin tests_failed++; $display("FAIL bp_hold cyc=%0d v=%b d=%h o=%0d want 1/4d/4", i, out_valid, out_data, out_ones); end
        end
        send_bit(1'b1, 1'b0, 1'b0);
        tests_run++; if (drop_err !== 1'b1 || out_data !== 8'h4D || out_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_drop drop=%b d=%h v=%b want 1/4d/1", drop_err, out_data, out_valid); end
        tick();
        tests_run++; if (drop_err !== 1'b0) begin tests_failed++; $display("FAIL bp_drop_pulse drop=%b want 0", drop_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || drop_err !== 1'b0) begin tests_failed++; $display("FAIL bp_accept v=%b drop=%b want 0/0", out_valid, drop_err); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || dut.state_reg !== ST_IDLE) begin tests_failed++; $display("FAIL bp_ready_idle v=%b state=%0d want 0/0", out_valid, dut.state_reg); end
        $display("[TB] backpressure: accepted word 4d");
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] pat = 8'hA5;
        word_t w, got;
        w.data = pat; w.ones = popcnt(pat); w.mode = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i == WIDTH - 1) exp_q.push_back(w);
            send_bit(hw1_o1(1'b0, pat[i], 1'b1, 1'b1), 1'b0, i == 0);
        end
        got = exp_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || out_data !== got.data || out_ones !== got.ones) begin tests_failed++; $display("FAIL b2b_first v=%b d=%h o=%0d want 1/%h/%0d", out_valid, out_data, out_ones, got.data, got.ones); end
        w.data = '1; w.ones = CNT_W'(WIDTH); w.mode = 1'b1;
        exp_q.push_back(w);
        out_ready = 1'b1;
        send_bit(hw1_o1(1'b1, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1);
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || out_data !== 8'h01 || out_mode !== 1'b1 || dut.state_reg !== ST_COLLECT) begin tests_failed++; $display("FAIL b2b_restart v=%b d=%h m=%b st=%0d want 0/01/1/1", out_valid, out_data, out_mode, dut.state_reg); end
        for (int i = 1; i < WIDTH; i++) begin
            send_bit(hw1_o1(1'b1, 1'b1, 1'b1, 1'b0), 1'b1, 1'b0);
            if (i < WIDTH - 1) begin
                tests_run++; if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_early bit=%0d v=%b want 0", i, out_valid); end
            end
        end
        got = exp_q.pop_front();
        tests_run++; if (out_valid !== 1'b1 || out_data !== got.data || out_ones !== got.ones || out_mode !== got.mode) begin tests_failed++; $display("FAIL b2b_second v=%b d=%h o=%0d m=%b want 1/%h/%0d/%b", out_valid, out_data, out_ones, out_mode, got.data, got.ones, got.mode); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests_run++; if (out_valid !== 1'b0 || drop_err !== 1'b0) begin tests_failed++; $display("FAIL b2b_accept v=%b drop=%b want 0/0", out_valid, drop_err); end
        $display("[TB] back_to_back: words a5 then ff");
    endtask

    task automatic test_abort();
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b1);
        tests_run++; if (drop_err !== 1'b1 || out_data !== 8'h01 || dut.idx_reg !== 1) begin tests_failed++; $display("FAIL abort_restart drop=%b d=%h idx=%0d want 1/01/1", drop_err, out_data, dut.idx_reg); end
        for (int i = 1; i < 5; i++) send_bit(1'b1, 1'b0, 1'b0);
        tests_run++; if (drop_err !== 1'b0 || out_data !== 8'h1F || out_ones !== 4'd5) begin tests_failed++; $display("FAIL abort_refill drop=%b d=%h o=%0d want 0/1f/5", drop_err, out_data, out_ones); end
        send_bit(1'b1, 1'b1, 1'b0);
        tests_run++; if (drop_err !== 1'b1 || out_valid !== 1'b0 || dut.state_reg !== ST_IDLE) begin tests_failed++; $display("FAIL abort_sel drop=%b v=%b st=%0d want 1/0/0", drop_err, out_valid, dut.state_reg); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++; if (out_valid !== 1'b0 || drop_err !== 1'b0) begin tests_failed++; $display("FAIL abort_idle cyc=%0d v=%b drop=%b want 0/0", i, out_valid, drop_err); end
        end
        $display("[TB] abort: two frames discarded");
    endtask

    task automatic test_random();
        int got_words = 0;
        int drops = 0;
        bit prod_done = 0;
        fork
            begin
                logic [WIDTH-1:0] acc;
                logic sel, b;
                word_t w;
                int waitc;
                for (int f = 0; f < 100; f++) begin
                    sel = 1'($urandom_range(0, 1));
                    acc = '0;
                    for (int i = 0; i < WIDTH; i++) begin
                        while ($urandom_range(0, 9) >= 3) tick();
                        waitc = 0;
                        while (i == 0 && out_valid && waitc < 1000) begin tick(); waitc++; end
                        if (waitc >= 1000) begin
                            tests_run++; tests_failed++;
                            $display("FAIL rand_wait_idle frame=%0d out_valid stuck=%b want 0", f, out_valid);
                        end
                        b = hw1_o1(sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                        acc[i] = b;
                        if (i == WIDTH - 1) begin
                            w.data = acc; w.ones = popcnt(acc); w.mode = sel;
                            exp_q.push_back(w);
                        end
                        send_bit(b, sel, i == 0);
                    end
                end
                prod_done = 1;
            end
            begin
                word_t exp_w;
                int cyc = 0;
                while (got_words < 100 && cyc < 20000) begin
                    out_ready = ($urandom_range(0, 1) == 1);
                    if (out_valid && out_ready) begin
                        tests_run++;
                        if (exp_q.size() == 0) begin
                            tests_failed++; $display("FAIL rand_word n=%0d got=%h with empty scoreboard", got_words, out_data);
                        end else begin
                            exp_w = exp_q.pop_front();
                            if (out_data !== exp_w.data || out_ones !== exp_w.ones || out_mode !== exp_w.mode) begin
                                tests_failed++; $display("FAIL rand_word n=%0d d=%h o=%0d m=%b want %h/%0d/%b", got_words, out_data, out_ones, out_mode, exp_w.data, exp_w.ones, exp_w.mode);
                            end else begin
                                $display("[TB] rand word %0d: data=%h ones=%0d mode=%b", got_words, out_data, out_ones, out_mode);
                            end
                        end
                        got_words++;
                    end
                    tick();
                    if (drop_err) drops++;
                    cyc++;
                end
                out_ready = 1'b0;
            end
        join
        tests_run++; if (got_words != 100 || !prod_done) begin tests_failed++; $display("FAIL rand_count words=%0d want 100", got_words); end
        tests_run++; if (drops != 0) begin tests_failed++; $display("FAIL rand_drops drop_err pulses=%0d want 0", drops); end
        tests_run++; if (exp_q.size() != 0) begin tests_failed++; $display("FAIL rand_leftover scoreboard=%0d want 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
